// File: rtl/wr_buf_ctrl.sv
// Write buffer in front of a cache data array: merges into the youngest entry and
// drains the head through tag lookup, line allocation/fetch, data write and tag update.
module wr_buf_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LIST_DEPTH = 4,
    parameter int LIST_WIDTH = 32,
    parameter int WB_DEPTH   = 4,
    localparam int BYTES = DATA_WIDTH / 8,
    localparam int TW    = $clog2(LIST_DEPTH),
    localparam int OFF   = $clog2(LIST_WIDTH * BYTES),
    localparam int WW    = $clog2(LIST_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  acc_wr_valid,
    output logic                  acc_wr_ready,
    input  logic [ADDR_WIDTH-1:0] acc_wr_addr,
    input  logic [DATA_WIDTH-1:0] acc_wr_data,
    input  logic [BYTES-1:0]      acc_wr_strb,
    output logic                  acc_wr_done,

    output logic                  acc_req,
    output logic [2:0]            acc_cmd,
    output logic [ADDR_WIDTH-1:0] acc_index,
    output logic [TW-1:0]         acc_tag,
    input  logic                  acc_gnt,
    input  logic [2:0]            acc_status,
    input  logic [TW-1:0]         return_tag,
    input  logic [ADDR_WIDTH-1:0] return_index,

    output logic                  fetch_req,
    output logic [1:0]            fetch_cmd,
    output logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [TW-1:0]         fetch_tag,
    input  logic                  fetch_gnt,
    input  logic                  fetch_done,

    output logic                  mem_wen,
    output logic [TW+WW-1:0]      mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [BYTES-1:0]      mem_wstrb,
    input  logic                  mem_wready,

    input  logic                  flush_req,
    output logic                  wb_empty
);

    localparam int BW  = $clog2(BYTES);
    localparam int PW  = $clog2(WB_DEPTH);
    localparam int WAW = ADDR_WIDTH - BW;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, RETRY, ALLOC, FETCH_REQ, WAIT_FETCH, MEM_WR, UPDATE
    } state_t;

    state_t state, state_next;

    // Entries hold word addresses; the byte-offset bits of a request carry no meaning here.
    logic [WAW-1:0]        buf_waddr [WB_DEPTH];
    logic [DATA_WIDTH-1:0] buf_data  [WB_DEPTH];
    logic [BYTES-1:0]      buf_strb  [WB_DEPTH];

    logic [PW-1:0]         wr_ptr, rd_ptr, young_ptr;
    logic [PW:0]           count;
    logic [TW-1:0]         tag_q;
    logic [ADDR_WIDTH-1:0] index_q;
    logic                  victim_dirty;
    logic                  fetched;

    logic                  full, merge_hit, push, merge, pop;
    logic [WAW-1:0]        head_waddr;
    logic [ADDR_WIDTH-1:0] head_line;
    logic                  unused_byte_bits;

    assign unused_byte_bits = ^acc_wr_addr[BW-1:0];

    assign young_ptr  = wr_ptr - PW'(1);
    assign full       = (count == (PW+1)'(WB_DEPTH));
    assign head_waddr = buf_waddr[rd_ptr];
    assign head_line  = {head_waddr[WAW-1:OFF-BW], {OFF{1'b0}}};

    // The youngest entry is frozen only when it is also the head being drained.
    assign merge_hit = (count != '0)
                    && (acc_wr_addr[ADDR_WIDTH-1:BW] == buf_waddr[young_ptr])
                    && !((count == (PW+1)'(1)) && (state != IDLE));

    assign acc_wr_ready = !flush_req && (!full || merge_hit);
    assign push         = acc_wr_valid && acc_wr_ready && !merge_hit;
    assign merge        = acc_wr_valid && acc_wr_ready && merge_hit;
    assign pop          = (state == MEM_WR) && mem_wready;
    assign wb_empty     = (count == '0) && (state == IDLE);

    // NOTE: buffer storage is deliberately not reset; pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_waddr[wr_ptr] <= acc_wr_addr[ADDR_WIDTH-1:BW];
            buf_data[wr_ptr]  <= acc_wr_data;
            buf_strb[wr_ptr]  <= acc_wr_strb;
        end else if (merge) begin
            for (int b = 0; b < BYTES; b++) begin
                if (acc_wr_strb[b]) begin
                    buf_data[young_ptr][8*b +: 8] <= acc_wr_data[8*b +: 8];
                end
            end
            buf_strb[young_ptr] <= buf_strb[young_ptr] | acc_wr_strb;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            tag_q        <= '0;
            index_q      <= '0;
            victim_dirty <= 1'b0;
            fetched      <= 1'b0;
            acc_wr_done  <= 1'b0;
        end else begin
            state       <= state_next;
            acc_wr_done <= mem_wen && mem_wready;

            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase

            if ((state == LOOKUP) && acc_gnt
                && ((acc_status == 3'b001) || (acc_status == 3'b010))) begin
                tag_q   <= return_tag;
                fetched <= 1'b0;
            end

            if ((state == ALLOC) && acc_gnt) begin
                tag_q        <= return_tag;
                index_q      <= return_index;
                victim_dirty <= (acc_status == 3'b010);
                fetched      <= 1'b1;
            end
        end
    end

    // NOTE: every output and the next state get a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        acc_req    = 1'b0;
        acc_cmd    = 3'b000;
        acc_index  = '0;
        acc_tag    = '0;
        fetch_req  = 1'b0;
        fetch_cmd  = 2'b00;
        fetch_addr = '0;
        fetch_tag  = '0;
        mem_wen    = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        mem_wstrb  = '0;

        case (state)
            IDLE: begin
                if (count != '0) state_next = LOOKUP;
            end
            LOOKUP: begin
                acc_req   = 1'b1;
                acc_index = head_line;
                if (acc_gnt) begin
                    case (acc_status)
                        3'b001, 3'b010: state_next = MEM_WR;
                        3'b000:         state_next = ALLOC;
                        default:        state_next = RETRY;
                    endcase
                end
            end
            RETRY: begin
                state_next = LOOKUP;
            end
            ALLOC: begin
                acc_req   = 1'b1;
                acc_cmd   = 3'b010;
                acc_index = head_line;
                if (acc_gnt) state_next = FETCH_REQ;
            end
            FETCH_REQ: begin
                fetch_req = 1'b1;
                fetch_tag = tag_q;
                // A dirty victim is written back first; the fill follows under the same command.
                if (victim_dirty) begin
                    fetch_cmd  = 2'b10;
                    fetch_addr = index_q;
                end else begin
                    fetch_cmd  = 2'b01;
                    fetch_addr = head_line;
                end
                if (fetch_gnt) state_next = WAIT_FETCH;
            end
            WAIT_FETCH: begin
                if (fetch_done) state_next = MEM_WR;
            end
            MEM_WR: begin
                mem_wen   = 1'b1;
                mem_waddr = {tag_q, head_waddr[OFF-BW-1:0]};
                mem_wdata = buf_data[rd_ptr];
                mem_wstrb = buf_strb[rd_ptr];
                if (mem_wready) state_next = fetched ? UPDATE : IDLE;
            end
            UPDATE: begin
                acc_req = 1'b1;
                acc_cmd = 3'b100;
                acc_tag = tag_q;
                if (acc_gnt) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wr_buf_ctrl.sv
// Randomized bench for wr_buf_ctrl: responders play tag list, fetch unit and data array;
// a queue of buffered writes predicts every data-array write.
module tb_wr_buf_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        acc_wr_valid, acc_wr_ready, acc_wr_done;
    logic [31:0] acc_wr_addr, acc_wr_data;
    logic [3:0]  acc_wr_strb;
    logic        acc_req, acc_gnt;
    logic [2:0]  acc_cmd, acc_status;
    logic [31:0] acc_index, return_index;
    logic [1:0]  acc_tag, return_tag;
    logic        fetch_req, fetch_gnt, fetch_done;
    logic [1:0]  fetch_cmd, fetch_tag;
    logic [31:0] fetch_addr;
    logic        mem_wen, mem_wready;
    logic [6:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        flush_req, wb_empty;

    always #5 clk = ~clk;

    wr_buf_ctrl dut (
        .clk(clk), .rst(rst),
        .acc_wr_valid(acc_wr_valid), .acc_wr_ready(acc_wr_ready), .acc_wr_addr(acc_wr_addr),
        .acc_wr_data(acc_wr_data), .acc_wr_strb(acc_wr_strb), .acc_wr_done(acc_wr_done),
        .acc_req(acc_req), .acc_cmd(acc_cmd), .acc_index(acc_index), .acc_tag(acc_tag),
        .acc_gnt(acc_gnt), .acc_status(acc_status), .return_tag(return_tag),
        .return_index(return_index),
        .fetch_req(fetch_req), .fetch_cmd(fetch_cmd), .fetch_addr(fetch_addr),
        .fetch_tag(fetch_tag), .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_wready(mem_wready),
        .flush_req(flush_req), .wb_empty(wb_empty)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    typedef struct {
        logic [2:0]  status;
        logic [1:0]  tag;
        logic [31:0] index;
    } rsp_t;

    wr_t  sb[$];
    rsp_t lk_q[$];
    rsp_t al_q[$];

    int checks = 0;
    int errors = 0;

    bit          gnt_en = 1'b1;
    bit          done_en = 1'b1;
    bit          stray_done = 1'b0;
    bit          exp_alloc = 1'b0;
    bit          exp_update = 1'b0;
    bit          fetch_pend = 1'b0;
    bit          done_exp = 1'b0;
    logic [1:0]  cur_tag = 2'd0;
    logic [1:0]  exp_fcmd = 2'b00;
    logic [31:0] exp_faddr = 32'd0;
    int          retry_watch = 0;
    int          fstate = 0;
    int          fdelay = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:7], 7'b0};
    endfunction

    // Tag-list responder: random or scripted replies, protocol expectations tracked here.
    initial begin : tag_list
        rsp_t        r;
        logic [31:0] idx;
        logic [2:0]  exp_cmd;
        acc_gnt = 1'b0; acc_status = 3'b000; return_tag = 2'd0; return_index = 32'd0;
        forever begin
            @(negedge clk);
            acc_gnt = 1'b0;
            if (rst) begin
                retry_watch = 0;
            end else begin
                if (retry_watch == 2) begin
                    check("retry_relookup", {acc_req, acc_cmd}, {1'b1, 3'b000});
                    retry_watch = 0;
                end else if (retry_watch == 1) begin
                    check("retry_idle_req", acc_req, 1'b0);
                    retry_watch = 2;
                end
                if (retry_watch != 2 && acc_req && gnt_en && $urandom_range(2) != 0) begin
                    exp_cmd = exp_update ? 3'b100 : (exp_alloc ? 3'b010 : 3'b000);
                    check("acc_cmd", acc_cmd, exp_cmd);
                    acc_gnt = 1'b1;
                    return_index = $urandom;
                    return_tag   = 2'($urandom_range(3));
                    acc_status   = 3'b000;
                    case (acc_cmd)
                        3'b000: begin
                            check("lookup_index", acc_index,
                                  sb.size() > 0 ? line_of(sb[0].addr) : 32'hFFFF_FFFF);
                            if (lk_q.size() > 0) r = lk_q.pop_front();
                            else begin
                                case ($urandom_range(7))
                                    0, 1, 2: r.status = 3'b001;
                                    3:       r.status = 3'b010;
                                    4, 5:    r.status = 3'b000;
                                    6:       r.status = 3'b100;
                                    default: r.status = 3'b011;
                                endcase
                                r.tag = 2'($urandom_range(3));
                            end
                            acc_status = r.status;
                            return_tag = r.tag;
                            if (r.status == 3'b001 || r.status == 3'b010) cur_tag = r.tag;
                            else if (r.status == 3'b000) exp_alloc = 1'b1;
                            else retry_watch = 1;
                        end
                        3'b010: begin
                            if (al_q.size() > 0) r = al_q.pop_front();
                            else begin
                                idx = $urandom;
                                idx[6:0] = 7'd0;
                                r.status = ($urandom_range(1) != 0) ? 3'b010 : 3'b000;
                                r.tag    = 2'($urandom_range(3));
                                r.index  = idx;
                            end
                            acc_status   = r.status;
                            return_tag   = r.tag;
                            return_index = r.index;
                            cur_tag      = r.tag;
                            exp_fcmd     = (r.status == 3'b010) ? 2'b10 : 2'b01;
                            exp_faddr    = (r.status == 3'b010) ? r.index
                                         : (sb.size() > 0 ? line_of(sb[0].addr) : 32'd0);
                            fetch_pend   = 1'b1;
                            exp_alloc    = 1'b0;
                            exp_update   = 1'b1;
                        end
                        default: begin
                            check("update_tag", acc_tag, cur_tag);
                            exp_update = 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Fetch unit: grants after a random wait, returns fetch_done a few cycles later.
    initial begin : fetch_unit
        fetch_gnt = 1'b0; fetch_done = 1'b0;
        forever begin
            @(negedge clk);
            fetch_gnt = 1'b0;
            fetch_done = 1'b0;
            if (rst) begin
                fstate = 0;
            end else if (stray_done) begin
                fetch_done = 1'b1;
                stray_done = 1'b0;
            end else if (fstate == 0) begin
                if (fetch_req && $urandom_range(1) != 0) begin
                    check("fetch_cmd", fetch_cmd, fetch_pend ? exp_fcmd : 2'b11);
                    check("fetch_addr", fetch_addr, exp_faddr);
                    check("fetch_tag", fetch_tag, cur_tag);
                    fetch_pend = 1'b0;
                    fetch_gnt  = 1'b1;
                    fstate     = 1;
                    fdelay     = $urandom_range(3);
                end
            end else if (done_en) begin
                if (fdelay == 0) begin
                    fetch_done = 1'b1;
                    fstate = 0;
                end else begin
                    fdelay--;
                end
            end
        end
    end

    // Data-array monitor: pops the expected write for each accepted mem write.
    initial begin : mem_monitor
        wr_t e;
        mem_wready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_exp = 1'b0;
            end else begin
                if (done_exp || acc_wr_done) check("acc_wr_done", acc_wr_done, done_exp);
                done_exp = 1'b0;
            end
            mem_wready = ($urandom_range(3) != 0);
            if (!rst && mem_wen && mem_wready) begin
                if (sb.size() == 0) begin
                    check("mem_wr_unexpected", {1'b1, mem_waddr}, 8'd0);
                end else begin
                    e = sb.pop_front();
                    check("mem_waddr", mem_waddr, {cur_tag, e.addr[6:2]});
                    check("mem_wdata", mem_wdata, e.data);
                    check("mem_wstrb", mem_wstrb, e.strb);
                    done_exp = 1'b1;
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] a_in, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] a;
        wr_t         e;
        int          n;
        a = a_in;
        @(negedge clk);
        acc_wr_valid = 1'b1; acc_wr_addr = a; acc_wr_data = d; acc_wr_strb = s;
        for (n = 0; n < 2000; n++) begin
            #1;
            // With one modelled entry the drain state decides merging; steer clear of that case.
            if (sb.size() == 1 && a[31:2] == sb[0].addr[31:2]) begin
                a[2] = ~a[2];
                acc_wr_addr = a;
                #1;
            end
            if (acc_wr_ready) break;
            @(negedge clk);
        end
        if (n >= 2000) begin
            check("wr_accept_timeout", acc_wr_ready, 1'b1);
        end else if (sb.size() >= 2 && sb[sb.size()-1].addr[31:2] == a[31:2]) begin
            e = sb[sb.size()-1];
            for (int b = 0; b < 4; b++) if (s[b]) e.data[8*b +: 8] = d[8*b +: 8];
            e.strb = e.strb | s;
            sb[sb.size()-1] = e;
        end else begin
            sb.push_back('{addr: a, data: d, strb: s});
        end
        @(posedge clk);
        #1;
        acc_wr_valid = 1'b0;
    endtask

    task automatic wait_empty(input string name);
        int n;
        for (n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (wb_empty && sb.size() == 0 && !exp_update) break;
        end
        if (n >= 4000) check({name, "_drain_timeout"}, sb.size(), 0);
        check({name, "_wb_empty"}, wb_empty, 1'b1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        logic [31:0] a;
        rst = 1'b1; flush_req = 1'b0; acc_wr_valid = 1'b0;
        acc_wr_addr = '0; acc_wr_data = '0; acc_wr_strb = '0;
        repeat (3) @(negedge clk);

        check("rst_acc_req", acc_req, 1'b0);
        check("rst_fetch_req", fetch_req, 1'b0);
        check("rst_mem_wen", mem_wen, 1'b0);
        check("rst_wr_done", acc_wr_done, 1'b0);
        check("rst_cmds", {acc_cmd, fetch_cmd}, 5'd0);
        check("rst_wb_empty", wb_empty, 1'b1);
        check("rst_ready", acc_wr_ready, 1'b1);
        flush_req = 1'b1;
        #1 check("flush_blocks_ready", acc_wr_ready, 1'b0);
        flush_req = 1'b0;
        #1 check("flush_release_ready", acc_wr_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Clean hit: tag 2, word 1 of its line.
        lk_q.push_back('{status: 3'b001, tag: 2'd2, index: 32'd0});
        do_write(32'h0000_0104, 32'hA5A5_A5A5, 4'b1111);
        check("hit_not_empty", wb_empty, 1'b0);
        wait_empty("hit");

        // Merge into a non-head entry while the head is stuck in lookup.
        gnt_en = 1'b0;
        do_write(32'h0000_0300, 32'h0BAD_F00D, 4'b1111);
        do_write(32'h0000_0200, 32'hDEAD_1122, 4'b0011);
        do_write(32'h0000_0200, 32'h3344_BEEF, 4'b1100);
        gnt_en = 1'b1;
        wait_empty("merge");

        // Dirty miss: writeback of the victim line, then fill, data write and update.
        lk_q.push_back('{status: 3'b000, tag: 2'd0, index: 32'd0});
        al_q.push_back('{status: 3'b010, tag: 2'd1, index: 32'h0000_0800});
        do_write(32'h0000_7044, 32'hCAFE_0001, 4'b0101);
        wait_empty("dirty_miss");

        // Full buffer: distinct address blocked, youngest word still merges.
        gnt_en = 1'b0;
        for (int i = 0; i < 4; i++) do_write(32'h6000 + 32'(i * 4), $urandom, 4'b1111);
        @(negedge clk);
        acc_wr_valid = 1'b1; acc_wr_addr = 32'h0000_6010; acc_wr_data = '0; acc_wr_strb = 4'b1111;
        #1 check("full_distinct_ready", acc_wr_ready, 1'b0);
        acc_wr_addr = 32'h0000_600C;
        #1 check("full_merge_ready", acc_wr_ready, 1'b1);
        acc_wr_valid = 1'b0;
        do_write(32'h0000_600C, 32'h0000_00EE, 4'b0001);
        gnt_en = 1'b1;
        wait_empty("full");

        // Busy line: one idle retry cycle, then lookup again.
        lk_q.push_back('{status: 3'b100, tag: 2'd0, index: 32'd0});
        lk_q.push_back('{status: 3'b001, tag: 2'd3, index: 32'd0});
        do_write(32'h0000_3000, 32'h1357_9BDF, 4'b1111);
        wait_empty("busy");

        // Reset while waiting on a fetch discards the buffered write.
        lk_q.push_back('{status: 3'b000, tag: 2'd0, index: 32'd0});
        al_q.push_back('{status: 3'b000, tag: 2'd1, index: 32'd0});
        done_en = 1'b0;
        do_write(32'h0000_5008, 32'h1234_5678, 4'b1111);
        for (n = 0; n < 500 && fstate != 1; n++) @(negedge clk);
        if (n >= 500) check("reach_wait_fetch", fetch_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_wb_empty", wb_empty, 1'b1);
        check("midrst_no_mem_wen", mem_wen, 1'b0);
        check("midrst_no_reqs", {acc_req, fetch_req}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        sb.delete(); lk_q.delete(); al_q.delete();
        exp_alloc = 1'b0; exp_update = 1'b0; fetch_pend = 1'b0;
        done_en = 1'b1;
        stray_done = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("stray_done_ignored", {mem_wen, wb_empty}, 2'b01);
        end

        // Random traffic across a few lines with occasional merges into the youngest entry.
        for (int i = 0; i < 200; i++) begin
            if (sb.size() >= 2 && $urandom_range(3) == 0) a = sb[sb.size()-1].addr;
            else a = 32'h4000 + 32'($urandom_range(15) << 7) + 32'($urandom_range(31) << 2);
            a[1:0] = 2'($urandom_range(3));
            do_write(a, $urandom, 4'($urandom_range(1, 15)));
            repeat ($urandom_range(2)) @(negedge clk);
        end
        wait_empty("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
